// File: rtl/acc_div_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// Overflow and divide-by-zero results come back in one cycle; normal divisions take 8 CALC cycles.
module acc_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        ovf,
    output logic        dbz,
    output logic [15:0] op_cnt
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t     state;
    logic [7:0] r;
    logic [7:0] s;
    logic [7:0] dvsr;
    logic [2:0] cnt;

    logic [8:0] t;
    logic [7:0] diff;
    logic       qbit;
    logic [7:0] r_next;
    logic [7:0] s_next;

    // One restoring step. Because r < dvsr, the true difference always fits 8 bits.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
        t      = {r, s[7]};
        qbit   = (t >= {1'b0, dvsr});
        diff   = t[7:0] - dvsr;
        r_next = qbit ? diff : t[7:0];
        s_next = {s[6:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= '0;
            s         <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            op_cnt    <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == 8'd0) begin
                            quotient  <= '0;
                            remainder <= '0;
                            ovf       <= 1'b0;
                            dbz       <= 1'b1;
                            done      <= 1'b1;
                            op_cnt    <= op_cnt + 16'd1;
                        end else if (dividend[15:8] >= divisor) begin
                            // Quotient would need more than 8 bits: saturate.
                            quotient  <= 8'hFF;
                            remainder <= '0;
                            ovf       <= 1'b1;
                            dbz       <= 1'b0;
                            done      <= 1'b1;
                            op_cnt    <= op_cnt + 16'd1;
                        end else begin
                            r     <= dividend[15:8];
                            s     <= dividend[7:0];
                            dvsr  <= divisor;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r   <= r_next;
                    s   <= s_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        quotient  <= s_next;
                        remainder <= r_next;
                        ovf       <= 1'b0;
                        dbz       <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        op_cnt    <= op_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_div_seq.sv
// Scoreboard bench for acc_div_seq: stimulus pushes model results, a negedge monitor pops on done.
module tb_acc_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dbz;
    logic [15:0] op_cnt;

    acc_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dbz;
        logic [15:0] cnt;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] exp_cnt = '0;
    int          errors  = 0;
    int          checks  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Division defined directly by its arithmetic meaning.
    function automatic res_t model(input int dvd, input int dvs, input logic [15:0] cnt);
        res_t e;
        e.cnt = cnt;
        if (dvs == 0) begin
            e.q = 8'd0; e.r = 8'd0; e.ovf = 1'b0; e.dbz = 1'b1;
        end else if (dvd >= 256 * dvs) begin
            e.q = 8'hFF; e.r = 8'd0; e.ovf = 1'b1; e.dbz = 1'b0;
        end else begin
            e.q = 8'(dvd / dvs); e.r = 8'(dvd % dvs); e.ovf = 1'b0; e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic push(input int dvd, input int dvs);
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back(model(dvd, dvs, exp_cnt));
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result{q,r,ovf,dbz,op_cnt}", {30'd0, quotient, remainder, ovf, dbz, op_cnt}, {30'd0, e});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Starts one op at posedge+1 and returns in its done cycle, checking latency and busy length.
    task automatic run_op(input int dvd, input int dvs, input string tag);
        int n;
        int bcnt;
        bit exc;
        n    = 0;
        bcnt = 0;
        exc  = (dvs == 0) || (dvd >= 256 * dvs);
        dividend = 16'(dvd);
        divisor  = 8'(dvs);
        start    = 1'b1;
        push(dvd, dvs);
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && n < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            n++;
        end
        if (busy) bcnt++;
        check({tag, "_latency"}, 64'(n), exc ? 64'd0 : 64'd8);
        check({tag, "_busy_cycles"}, 64'(bcnt), exc ? 64'd0 : 64'd8);
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int dn;
        int dvs;
        int dvd;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        check("reset_outputs", {33'd0, busy, done, quotient, remainder, ovf, dbz, op_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(1000, 7, "d1000_7");
        run_op(767, 3, "d767_3");
        run_op(768, 3, "d768_3");
        run_op(500, 0, "d500_0");
        run_op(65535, 255, "d65535_255");
        run_op(65279, 255, "d65279_255");
        @(posedge clk); #1;

        // Back-to-back with start held, plus an ignored start pulse mid-CALC.
        dividend = 16'd4660;
        divisor  = 8'd64;
        start    = 1'b1;
        push(4660, 64);
        push(4660, 64);
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_latency", 64'(n), 64'd8);
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            start = (n == 3);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("b2b_done_gap", 64'(n), 64'd9);
        dn = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("no_extra_done", 64'(dn), 64'd0);

        // Reset in the middle of a division.
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        push(1000, 7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        check("midop_reset_outputs", {33'd0, busy, done, quotient, remainder, ovf, dbz, op_cnt}, 64'd0);
        dn = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("midop_reset_no_done", 64'(dn), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(100, 10, "d100_10_after_reset");

        // Randomized mix of normal, overflow and divide-by-zero operations.
        for (int k = 0; k < 40; k++) begin
            dvs = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            if (dvs == 0 || $urandom_range(0, 3) == 0)
                dvd = int'($urandom_range(0, 65535));
            else
                dvd = int'($urandom_range(0, 256 * dvs - 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            run_op(dvd, dvs, "random");
        end
        @(posedge clk); #1;
        check("queue_drained_random", 64'(exp_q.size()), 64'd0);

        // Counter wrap: 65536 back-to-back divide-by-zero operations.
        do_reset();
        dividend = 16'd500;
        divisor  = 8'd0;
        start    = 1'b1;
        for (int k = 0; k < 65536; k++) push(500, 0);
        repeat (65536) @(posedge clk);
        #1 start = 1'b0;
        check("wrap_op_cnt", 64'(op_cnt), 64'd0);
        check("wrap_last_done", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        check("queue_drained_wrap", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
